// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller for the IF stage irq[7:0] vector.
// Latches source requests, applies the mask and global enable, and issues
// one one-hot, single-cycle irq pulse. Bit 0 has the highest priority.
// The return PC is captured into EPC, and no further irq is issued until ID
// pulses irq_ret. A small register port gives access to MASK, PENDING, CTRL
// and EPC.
// Optional feature macro: IRQ_LEVEL_EN. When it is defined, pending is the
// combinational level src & mask instead of an edge-latched register.
module irq_ctrl #(
  parameter int CPU_WIDTH = 16,
  parameter int NUM_SRC   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src,
  input  logic [CPU_WIDTH-1:0] next_pc,
  input  logic                 irq_ret,
  input  logic                 wr_en,
  input  logic [1:0]           addr,
  input  logic [CPU_WIDTH-1:0] wr_data,
  output logic [CPU_WIDTH-1:0] rd_data,
  output logic [7:0]           irq,
  output logic                 in_service,
  output logic [CPU_WIDTH-1:0] epc
);

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_EPC  = 2'd3;

  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC-1:0]   irq_q, irq_d;
  logic                 gie_q, gie_d;
  logic                 in_service_q, in_service_d;
  logic [CPU_WIDTH-1:0] epc_q, epc_d;

  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   sel;
  logic                 irq_active;
  logic                 issue;
  logic                 wr_mask, wr_pend, wr_ctrl;

  // Upper write-data bits are not backed by any register.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  assign wr_mask = wr_en && (addr == A_MASK);
  assign wr_pend = wr_en && (addr == A_PEND);
  assign wr_ctrl = wr_en && (addr == A_CTRL);

`ifdef IRQ_LEVEL_EN
  // Level mode: a request is live exactly while its masked source is high.
  // PENDING writes are ignored because there is no latch to clear.
  logic unused_wr_pend;
  assign unused_wr_pend = wr_pend;
  assign pending = src & mask_q;
`else
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] rise;

  assign rise    = src & ~src_prev_q;
  assign pending = pending_q;

  // Pending latch update. A new rise beats the W1C clear and beats the
  // clear of the bit that was just issued.
  always_comb begin
    pending_d  = pending_q;
    src_prev_d = src;
    if (wr_pend)    pending_d = pending_d & ~wr_data[NUM_SRC-1:0];
    if (irq_active) pending_d = pending_d & ~irq_q;
    pending_d = pending_d | rise;
  end

  // Edge-capture state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      src_prev_q <= '0;
    end else begin
      pending_q  <= pending_d;
      src_prev_q <= src_prev_d;
    end
  end
`endif

  // The lowest set index wins. x & -x isolates the least-significant one.
  assign req        = pending & mask_q;
  assign sel        = req & (~req + NUM_SRC'(1));
  assign irq_active = |irq_q;
  assign issue      = gie_q & ~in_service_q & ~irq_active & (|req);

  // Control-state next values. Issue is gated on registered mask and gie,
  // so register writes affect the decision one cycle later.
  always_comb begin
    mask_d       = mask_q;
    gie_d        = gie_q;
    irq_d        = issue ? sel : '0;
    in_service_d = in_service_q;
    epc_d        = epc_q;
    if (wr_mask) mask_d = wr_data[NUM_SRC-1:0];
    if (wr_ctrl) gie_d  = wr_data[0];
    if (irq_ret) in_service_d = 1'b0;
    // The irq cycle commits the handler entry. An irq_ret that arrives
    // while not in service is ignored.
    if (irq_active) begin
      in_service_d = 1'b1;
      epc_d        = next_pc;
    end
  end

  // Control-state registers. Reset drops any in-flight pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= '0;
      gie_q        <= 1'b0;
      irq_q        <= '0;
      in_service_q <= 1'b0;
      epc_q        <= '0;
    end else begin
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
      epc_q        <= epc_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    rd_data = '0;
    unique case (addr)
      A_MASK: rd_data = CPU_WIDTH'(mask_q);
      A_PEND: rd_data = CPU_WIDTH'(pending);
      A_CTRL: rd_data = CPU_WIDTH'({in_service_q, gie_q});
      A_EPC:  rd_data = epc_q;
      default: rd_data = '0;
    endcase
  end

  assign irq        = 8'(irq_q);
  assign in_service = in_service_q;
  assign epc        = epc_q;

endmodule
